// File: rtl/sr_ctrl_pkg.sv
// Shared types and sizing helpers for the SR flag-bank controller.
// Widths that depend on block parameters are exposed as functions.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    VERIFY
  } state_t;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rcw(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Produces a one-hot grant plus the binary id of the winner.
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [idxw(N)-1:0]   ptr,
  output logic [N-1:0]         grant,
  output logic [idxw(N)-1:0]   id
);

  localparam int IDW = idxw(N);

  logic [2*N-1:0] w_rot;
  logic [IDW:0]   w_sum;
  logic           w_found;

  assign w_rot = {req, req} >> ptr;

  always_comb begin
    grant   = '0;
    id      = '0;
    w_sum   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
        id      = w_sum[IDW-1:0];
        grant   = N'(1) << w_sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrates set/clear requests onto an SR flip-flop bank, drives one-cycle S/R
// pulses, verifies via Q read-back and retries; S and R are never both high.
module sr_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NFLAGS    = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             op,
  input  logic [NREQ*idxw(NFLAGS)-1:0] idx,
  output logic [NREQ-1:0]             gnt,
  output logic                        err,
  output logic                        fail_sticky,
  output logic                        busy,
  output logic [NFLAGS-1:0]           s_out,
  output logic [NFLAGS-1:0]           r_out,
  input  logic [NFLAGS-1:0]           q_in
);

  localparam int IDXW = idxw(NFLAGS);
  localparam int IDW  = idxw(NREQ);
  localparam int RCW  = rcw(MAX_RETRY);

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, r_cur_id, w_win_id;
  logic              r_cur_op, r_bad_idx, r_fail;
  logic [IDXW-1:0]   r_cur_idx;
  logic [RCW-1:0]    r_retry;
  logic [NFLAGS-1:0] r_s_out, r_r_out;

  logic [NREQ-1:0]   w_win_gnt;
  logic              w_any, w_req_op, w_req_bad, w_req_q, w_cur_q;
  logic [IDXW-1:0]   w_req_idx, w_drv_idx;
  logic [NFLAGS-1:0] w_req_mask, w_cur_mask, w_drv_mask;
  logic              w_ok, w_retry_ok, w_done, w_drv_op;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req),
    .ptr   (r_rr_ptr),
    .grant (w_win_gnt),
    .id    (w_win_id)
  );

  assign w_any     = |w_win_gnt;
  assign w_req_op  = op[w_win_id];
  assign w_req_idx = idx[w_win_id*IDXW +: IDXW];
  assign w_req_bad = int'(w_req_idx) >= NFLAGS;

  // Shifted masks read out-of-range indices as 0 instead of indexing past q_in.
  assign w_req_mask = NFLAGS'(1) << w_req_idx;
  assign w_cur_mask = NFLAGS'(1) << r_cur_idx;
  assign w_req_q    = |(q_in & w_req_mask);
  assign w_cur_q    = |(q_in & w_cur_mask);

  assign w_ok       = !r_bad_idx && (w_cur_q == r_cur_op);
  assign w_retry_ok = !r_bad_idx && (int'(r_retry) < MAX_RETRY);

  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    err         = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_req_bad || (w_req_q == w_req_op)) w_state_nxt = VERIFY;
          else                                     w_state_nxt = DRIVE;
        end
      end
      DRIVE: w_state_nxt = VERIFY;
      VERIFY: begin
        if (w_ok) begin
          gnt         = NREQ'(1) << r_cur_id;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_retry_ok) begin
          w_state_nxt = DRIVE;
        end else begin
          gnt         = NREQ'(1) << r_cur_id;
          err         = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Drive target comes from the fresh winner on entry, else from the latched op.
  assign w_drv_idx  = (r_state == IDLE) ? w_req_idx : r_cur_idx;
  assign w_drv_op   = (r_state == IDLE) ? w_req_op  : r_cur_op;
  assign w_drv_mask = NFLAGS'(1) << w_drv_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_cur_id  <= '0;
      r_cur_op  <= 1'b0;
      r_cur_idx <= '0;
      r_bad_idx <= 1'b0;
      r_retry   <= '0;
      r_fail    <= 1'b0;
      r_s_out   <= '0;
      r_r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_cur_id  <= w_win_id;
        r_cur_op  <= w_req_op;
        r_cur_idx <= w_req_idx;
        r_bad_idx <= w_req_bad;
        r_retry   <= '0;
      end else if (r_state == VERIFY && w_state_nxt == DRIVE) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_done) begin
        r_rr_ptr <= (r_cur_id == IDW'(NREQ-1)) ? '0 : r_cur_id + 1'b1;
      end
      if (err) r_fail <= 1'b1;
      if (w_state_nxt == DRIVE) begin
        r_s_out <= (w_drv_op == OP_SET) ? w_drv_mask : '0;
        r_r_out <= (w_drv_op == OP_SET) ? '0 : w_drv_mask;
      end else begin
        r_s_out <= '0;
        r_r_out <= '0;
      end
    end
  end

  assign s_out       = r_s_out;
  assign r_out       = r_r_out;
  assign fail_sticky = r_fail;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Scoreboard bench for sr_bank_ctrl: directed requests push expected grants and
// drive pulses; negedge monitors pop and compare, plus per-cycle invariants.
module tb_sr_bank_ctrl;

  typedef struct {
    logic [3:0] gnt;
    logic       err;
    int         cyc;
  } gexp_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] r;
    int         cyc;
  } dexp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, op, gnt;
  logic [11:0] idx;
  logic        err, fail_sticky, busy;
  logic [7:0]  s_out, r_out, q_in;
  logic [7:0]  bank_q    = '0;
  logic [7:0]  stuck     = '0;
  logic [7:0]  tb_preset = '0;

  logic [3:0]  req6, op6, gnt6;
  logic [11:0] idx6;
  logic        err6, fail6, busy6;
  logic [5:0]  s6, r6, q6;
  logic [5:0]  bank6 = '0;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t gq6[$];
  dexp_t dq6[$];
  gexp_t gm, gm6;
  dexp_t dm, dm6;

  sr_bank_ctrl #(.NREQ(4), .NFLAGS(8), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .err(err), .fail_sticky(fail_sticky), .busy(busy),
    .s_out(s_out), .r_out(r_out), .q_in(q_in)
  );

  sr_bank_ctrl #(.NREQ(4), .NFLAGS(6), .MAX_RETRY(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .op(op6), .idx(idx6),
    .gnt(gnt6), .err(err6), .fail_sticky(fail6), .busy(busy6),
    .s_out(s6), .r_out(r6), .q_in(q6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SR bank; a stuck mask models a flop whose Q never rises.
  assign q_in = bank_q & ~stuck;
  assign q6   = bank6;
  always @(posedge clk) begin
    bank_q <= (bank_q | s_out | tb_preset) & ~r_out;
    bank6  <= (bank6 | s6) & ~r6;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (gnt != 4'b0) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else begin
        gm = gq.pop_front();
        chk("gnt_id", 32'(gnt), 32'(gm.gnt));
        chk("gnt_err", 32'(err), 32'(gm.err));
        chk("gnt_cycle", cyc, gm.cyc);
      end
    end
    if ((s_out | r_out) != 8'h00) begin
      if (dq.size() == 0) chk("drive_unexpected", 32'(s_out | r_out), 32'd0);
      else begin
        dm = dq.pop_front();
        chk("drive_s", 32'(s_out), 32'(dm.s));
        chk("drive_r", 32'(r_out), 32'(dm.r));
        chk("drive_cycle", cyc, dm.cyc);
      end
    end
    chk("s_and_r", 32'(s_out & r_out), 32'd0);
    chk("drive_onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  end

  always @(negedge clk) begin
    if (gnt6 != 4'b0) begin
      if (gq6.size() == 0) chk("gnt6_unexpected", 32'(gnt6), 32'd0);
      else begin
        gm6 = gq6.pop_front();
        chk("gnt6_id", 32'(gnt6), 32'(gm6.gnt));
        chk("gnt6_err", 32'(err6), 32'(gm6.err));
        chk("gnt6_cycle", cyc, gm6.cyc);
      end
    end
    if ((s6 | r6) != 6'h00) begin
      if (dq6.size() == 0) chk("drive6_unexpected", 32'(s6 | r6), 32'd0);
      else begin
        dm6 = dq6.pop_front();
        chk("drive6_s", 32'(s6), 32'(dm6.s));
        chk("drive6_r", 32'(r6), 32'(dm6.r));
        chk("drive6_cycle", cyc, dm6.cyc);
      end
    end
    chk("s6_and_r6", 32'(s6 & r6), 32'd0);
  end

  task automatic exp_g(input logic [3:0] g, input logic e, input int c);
    gexp_t x;
    x.gnt = g; x.err = e; x.cyc = c;
    gq.push_back(x);
  endtask

  task automatic exp_d(input logic [7:0] s, input logic [7:0] r, input int c);
    dexp_t x;
    x.s = s; x.r = r; x.cyc = c;
    dq.push_back(x);
  endtask

  task automatic exp_g6(input logic [3:0] g, input logic e, input int c);
    gexp_t x;
    x.gnt = g; x.err = e; x.cyc = c;
    gq6.push_back(x);
  endtask

  task automatic exp_d6(input logic [7:0] s, input logic [7:0] r, input int c);
    dexp_t x;
    x.s = s; x.r = r; x.cyc = c;
    dq6.push_back(x);
  endtask

  task automatic issue(input int k, input logic o, input int ix);
    req[k] = 1'b1;
    op[k]  = o;
    idx[k*3 +: 3] = 3'(ix);
  endtask

  task automatic issue6(input int k, input logic o, input int ix);
    req6[k] = 1'b1;
    op6[k]  = o;
    idx6[k*3 +: 3] = 3'(ix);
  endtask

  // Requesters drop req on the negedge where they see their gnt bit.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req  = req & ~gnt;
      req6 = req6 & ~gnt6;
    end
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    req = '0; op = '0; idx = '0;
    req6 = '0; op6 = '0; idx6 = '0;
    run(3);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_r_out", 32'(r_out), 32'd0);
    chk("rst_fail", 32'(fail_sticky), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Single set of flag 3.
    issue(0, 1'b1, 3); c = cyc;
    exp_d(8'h08, 8'h00, c + 1);
    exp_g(4'b0001, 1'b0, c + 2);
    run(1);
    chk("busy_in_drive", 32'(busy), 32'd1);
    run(3);

    // Skip path: flag 5 already set.
    tb_preset = 8'h20; run(1); tb_preset = 8'h00; run(1);
    issue(1, 1'b1, 5); c = cyc;
    exp_g(4'b0010, 1'b0, c + 1);
    run(4);

    // Clear flag 3 from requester 3; pointer wraps to 0.
    issue(3, 1'b0, 3); c = cyc;
    exp_d(8'h00, 8'h08, c + 1);
    exp_g(4'b1000, 1'b0, c + 2);
    run(4);

    // Round robin with all requesters; requester 0 returns while others wait.
    issue(0, 1'b1, 0); issue(1, 1'b1, 1); issue(2, 1'b1, 4); issue(3, 1'b1, 6);
    c = cyc;
    exp_d(8'h01, 8'h00, c + 1);  exp_g(4'b0001, 1'b0, c + 2);
    exp_d(8'h02, 8'h00, c + 4);  exp_g(4'b0010, 1'b0, c + 5);
    exp_d(8'h10, 8'h00, c + 7);  exp_g(4'b0100, 1'b0, c + 8);
    exp_d(8'h40, 8'h00, c + 10); exp_g(4'b1000, 1'b0, c + 11);
    exp_d(8'h00, 8'h01, c + 13); exp_g(4'b0001, 1'b0, c + 14);
    run(3);
    issue(0, 1'b0, 0);
    run(15);

    // Stuck-at-0 flag 2: three drives then error.
    chk("fail_before_stuck", 32'(fail_sticky), 32'd0);
    stuck = 8'h04;
    issue(2, 1'b1, 2); c = cyc;
    exp_d(8'h04, 8'h00, c + 1);
    exp_d(8'h04, 8'h00, c + 3);
    exp_d(8'h04, 8'h00, c + 5);
    exp_g(4'b0100, 1'b1, c + 6);
    run(8);
    chk("fail_after_stuck", 32'(fail_sticky), 32'd1);
    run(3);
    chk("fail_persists", 32'(fail_sticky), 32'd1);

    // Six-flag bank: indices 7 and 6 are out of range, 5 is the last valid one.
    chk("fail6_initial", 32'(fail6), 32'd0);
    issue6(0, 1'b1, 7); c = cyc;
    exp_g6(4'b0001, 1'b1, c + 1);
    run(3);
    chk("fail6_after_bad", 32'(fail6), 32'd1);
    issue6(1, 1'b1, 6); c = cyc;
    exp_g6(4'b0010, 1'b1, c + 1);
    run(3);
    issue6(2, 1'b1, 5); c = cyc;
    exp_d6(8'h20, 8'h00, c + 1);
    exp_g6(4'b0100, 1'b0, c + 2);
    run(4);

    // Reset in the middle of a drive.
    issue(1, 1'b1, 7);
    @(posedge clk);
    #2;
    chk("drive_before_reset", 32'(s_out), 32'h80);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("reset_s_out_async", 32'(s_out), 32'd0);
    chk("reset_busy_async", 32'(busy), 32'd0);
    chk("reset_gnt_async", 32'(gnt), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(2);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_fail", 32'(fail_sticky), 32'd0);
    issue(2, 1'b0, 1); issue(3, 1'b1, 3); c = cyc;
    exp_d(8'h00, 8'h02, c + 1); exp_g(4'b0100, 1'b0, c + 2);
    exp_d(8'h08, 8'h00, c + 4); exp_g(4'b1000, 1'b0, c + 5);
    run(8);

    chk("gnt_queue_drained", gq.size(), 32'd0);
    chk("drive_queue_drained", dq.size(), 32'd0);
    chk("gnt6_queue_drained", gq6.size(), 32'd0);
    chk("drive6_queue_drained", dq6.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_bank_ctrl.md
Name: sr_bank_ctrl

Overview:
Sequencing controller and arbiter for a bank of NFLAGS edge-triggered SR flip-flops shared by NREQ requesters. Each requester asks to set or clear one flag. The block grants requesters round-robin and drives one-cycle S or R pulses into the bank. It reads back Q to verify each write, retries on mismatch, and guarantees the bank never sees S=R=1.

Parameters:
NREQ, 4, number of requesters (2..8)
NFLAGS, 8, number of SR flip-flops in the bank (1..32)
MAX_RETRY, 2, extra drive attempts after a failed verify before reporting error

Ports:
clk  in  1  rising-edge clock, shared with the SR flip-flop bank
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held high until its gnt bit pulses
op  in  NREQ  per-requester operation: 1 = set, 0 = clear
idx  in  NREQ*IDXW  per-requester flag index; requester k uses bits [k*IDXW +: IDXW]
gnt  out  NREQ  one-hot, one-cycle completion pulse to the winning requester
err  out  1  pulses with gnt when the operation failed
fail_sticky  out  1  set on any err; cleared only by reset
busy  out  1  high whenever state != IDLE
s_out  out  NFLAGS  S inputs to the bank, registered
r_out  out  NFLAGS  R inputs to the bank, registered
q_in  in  NFLAGS  Q outputs read back from the bank

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; gnt, err, fail_sticky, busy, s_out and r_out all 0; rr_ptr=0; retry count 0. Reset mid-operation aborts the operation immediately: no gnt, outputs drop without waiting for clk.
- Invariants on every cycle: (s_out & r_out)==0; popcount(s_out|r_out)<=1; popcount(gnt)<=1.
- Arbitration happens in IDLE only:
  - Search req starting at rr_ptr, wrapping modulo NREQ; the first asserted bit wins.
  - At the clock edge, latch cur_id, cur_op and cur_idx.
  - rr_ptr becomes (cur_id+1) mod NREQ when that operation completes, whether it succeeds or fails.
- States:
  - IDLE: no req -> IDLE. Winner with cur_idx >= NFLAGS -> VERIFY with bad_idx flag set. Winner whose target flag already equals op -> VERIFY (skip path, no drive). Otherwise -> DRIVE.
  - DRIVE: exactly one cycle. s_out[cur_idx]=cur_op and r_out[cur_idx]=!cur_op; all other bits 0. The bank captures at the end of this cycle. Next state -> VERIFY.
  - VERIFY: s_out and r_out are 0.
    - Success: q_in[cur_idx]==cur_op and not bad_idx. gnt[cur_id]=1, err=0, next -> IDLE.
    - Mismatch with retries < MAX_RETRY: increment retries, next -> DRIVE, no gnt.
    - Mismatch with retries exhausted, or bad_idx: gnt[cur_id]=1, err=1, fail_sticky<=1, next -> IDLE. A bad index is never driven and never retried.
- Latency, counted from the edge at which req is sampled in IDLE:
  - Normal: gnt 2 cycles later (DRIVE, then VERIFY).
  - Skip path: gnt 1 cycle later.
  - Each retry adds 2 cycles.
  - Back-to-back: the next arbitration occurs in the cycle after gnt, so the minimum spacing is 3 cycles per driven op.
- Handshake: the requester drops req the cycle after gnt. If req drops early, the in-flight op still completes and gnt still pulses. Changes to op/idx after latch are ignored.
- Requests arriving while busy wait; all requesters are served in round-robin order, so there is no starvation.

Decomposition:
- Package sr_ctrl_pkg holds:
  - state enum {IDLE, DRIVE, VERIFY}
  - constants OP_CLR=1'b0 and OP_SET=1'b1
  - IDXW = (NFLAGS>1) ? $clog2(NFLAGS) : 1
  - retry counter width = $clog2(MAX_RETRY+1)
- Sub-module rr_arbiter (parameter N): inputs req and ptr; outputs one-hot grant and binary winner id; combinational.
- The FSM, latch registers and S/R drivers live in sr_bank_ctrl.

Test Plan:
1. Single set: reset, req[0]=1, op=1, idx=3, bank q=0 -> s_out=8'h08 for one cycle; gnt=4'b0001 two cycles after sampling; q_in[3]=1; err=0.
2. Skip path: bank q[5]=1; req[1] sets idx=5 -> no s_out/r_out activity; gnt=4'b0010 one cycle after sampling.
3. Round robin: req=4'b1111 held with distinct idx values -> gnt order 0,1,2,3, then 0 again; each driven op 3 cycles apart; s_out&r_out==0 on every cycle.
4. Stuck fault: force q_in[2]=0 and request set idx=2 -> 3 DRIVE pulses (1+MAX_RETRY); gnt with err=1 at cycle 6; fail_sticky=1 until reset.
5. Bad index: NFLAGS=6, idx=7 -> no drive; gnt+err one cycle after sampling; fail_sticky=1.
6. Reset mid-op: assert rst_n=0 during DRIVE -> s_out=0 immediately, no gnt; after release rr_ptr=0 and busy=0.
